// File: rtl/mnist_bit_rx_if.sv
// Byte stream from the MNIST bit receiver towards an image buffer or comparator.
interface mnist_bit_rx_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [6:0] byte_addr;
  logic       image_done;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_addr,
    output image_done
  );

  modport slave (
    input byte_valid,
    input byte_data,
    input byte_addr,
    input image_done
  );
endinterface

// File: rtl/mnist_bit_rx.sv
// Receive side of the MNIST bit link: filters the returning bit line, samples at
// mid-bit with edge-driven phase realignment and reassembles MSB-first image bytes.
module mnist_bit_rx #(
  parameter int unsigned BIT_CYCLES     = 4000,
  parameter int unsigned START_OFFSET   = 4006,
  parameter int unsigned BITS_PER_IMAGE = 784,
  parameter int unsigned MAX_IMAGES     = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           bit_in,
  mnist_bit_rx_if.master byte_if,
  output logic [15:0]    image_cnt,
  output logic [7:0]     err_cnt,
  output logic           busy
);

  localparam int unsigned PH_W  = $clog2(BIT_CYCLES);
  localparam int unsigned AL_W  = $clog2(START_OFFSET);
  localparam int unsigned BYTES = BITS_PER_IMAGE / 8;

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BIT_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_Q1    = PH_W'(BIT_CYCLES / 4);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(BIT_CYCLES / 2);
  localparam logic [PH_W-1:0] PH_Q3    = PH_W'((3 * BIT_CYCLES) / 4);
  localparam logic [AL_W-1:0] AL_LAST  = AL_W'(START_OFFSET - 1);
  localparam logic [AL_W-1:0] AL_EARLY = AL_W'(START_OFFSET - BIT_CYCLES / 4);
  localparam logic [6:0]      IDX_LAST = 7'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RECV
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [2:0]      samp_q, samp_d;
  logic            bit_f_q, bit_f_d;
  logic            bit_prev_q, bit_prev_d;
  logic [AL_W-1:0] align_q, align_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [15:0]     image_cnt_q, image_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic [6:0]      byte_addr_q, byte_addr_d;
  logic            image_done_q, image_done_d;
  logic            edge_det;

  always_comb begin
    // 2-flop synchronizer, then 2-of-3 majority rejects single-cycle glitches
    sync_d     = {sync_q[0], bit_in};
    samp_d     = {samp_q[1:0], sync_q[1]};
    bit_f_d    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    bit_prev_d = bit_f_q;
    edge_det   = bit_f_q ^ bit_prev_q;

    state_d      = state_q;
    align_d      = align_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    shreg_d      = shreg_q;
    image_cnt_d  = image_cnt_q;
    err_cnt_d    = err_cnt_q;
    byte_valid_d = 1'b0;
    image_done_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_addr_d  = byte_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          image_cnt_d = '0;
          err_cnt_d   = '0;
          bit_cnt_d   = '0;
          byte_idx_d  = '0;
          shreg_d     = '0;
          align_d     = '0;
          state_d     = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        align_d = align_q + 1'b1;
        if (align_q == AL_LAST || (edge_det && align_q >= AL_EARLY)) begin
          phase_d = '0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        // The mid-bit sample lies inside the no-resync window, so a resync can
        // neither skip nor repeat it.
        if (edge_det) begin
          if (phase_q < PH_Q1 || phase_q >= PH_Q3) begin
            phase_d = '0;
          end else if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        if (phase_q == PH_MID) begin
          shreg_d   = {shreg_q[6:0], bit_f_q};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shreg_d;
            byte_addr_d  = byte_idx_q;
            if (byte_idx_q == IDX_LAST) begin
              byte_idx_d   = '0;
              image_done_d = 1'b1;
              image_cnt_d  = image_cnt_q + 1'b1;
              if (MAX_IMAGES != 0 && image_cnt_d == 16'(MAX_IMAGES)) begin
                state_d = ST_IDLE;
              end
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      byte_valid_d = 1'b0;
      image_done_d = 1'b0;
      image_cnt_d  = image_cnt_q;
      err_cnt_d    = err_cnt_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      samp_q       <= '0;
      bit_f_q      <= 1'b0;
      bit_prev_q   <= 1'b0;
      align_q      <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      shreg_q      <= '0;
      image_cnt_q  <= '0;
      err_cnt_q    <= '0;
      busy_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_addr_q  <= '0;
      image_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      samp_q       <= samp_d;
      bit_f_q      <= bit_f_d;
      bit_prev_q   <= bit_prev_d;
      align_q      <= align_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      shreg_q      <= shreg_d;
      image_cnt_q  <= image_cnt_d;
      err_cnt_q    <= err_cnt_d;
      busy_q       <= busy_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_addr_q  <= byte_addr_d;
      image_done_q <= image_done_d;
    end
  end

  assign byte_if.byte_valid = byte_valid_q;
  assign byte_if.byte_data  = byte_data_q;
  assign byte_if.byte_addr  = byte_addr_q;
  assign byte_if.image_done = image_done_q;
  assign image_cnt          = image_cnt_q;
  assign err_cnt            = err_cnt_q;
  assign busy               = busy_q;

endmodule
